imem_fetch: RTL and testbench

Instruction-memory responder for the 8-bit computer: the far end of the program counter's fetch path. It accepts instruction addresses from the fetch side over a valid/ready request channel, reads a 256-entry instruction store, and returns each instruction with its address over a valid/ready response channel through a 3-entry buffer. A flush input discards all in-flight fetches when the control unit takes a branch.

---
 rtl/imem_fetch.sv | 118 +++++++++++
 tb/tb_imem_fetch.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch.sv
// imem_fetch: 256-entry instruction store, registered read, 3-deep response FIFO.
// Define IMEM_LOAD_EN to add the wr_en/wr_addr/wr_data program-load port.
module imem_fetch #(
  parameter int    IW        = 8,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic [7:0]    req_addr,
  output logic          req_ready,
  output logic          rsp_valid,
  output logic [7:0]    rsp_addr,
  output logic [IW-1:0] rsp_data,
  input  logic          rsp_ready,
`ifdef IMEM_LOAD_EN
  input  logic          wr_en,
  input  logic [7:0]    wr_addr,
  input  logic [IW-1:0] wr_data,
`endif
  input  logic          flush
);

  logic [IW-1:0] mem [0:255];

`ifdef IMEM_LOAD_EN
  // Not gated by reset or flush: program load must work at any time.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
`endif

  logic          s1_valid_q, s1_valid_d;
  logic [7:0]    s1_addr_q, s1_addr_d;
  logic [IW-1:0] s1_data_q, s1_data_d;
  logic [1:0]    count_q, count_d;
  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [7:0]    fifo_addr_q [0:2];
  logic [7:0]    fifo_addr_d [0:2];
  logic [IW-1:0] fifo_data_q [0:2];
  logic [IW-1:0] fifo_data_d [0:2];

  logic       accept;
  logic       push;
  logic       pop;
  logic [2:0] occ;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Occupancy from current state only; a same-cycle pop does not help.
  assign occ       = {2'b00, s1_valid_q} + {1'b0, count_q};
  assign req_ready = rst_n && !flush && (occ < 3'd3);
  assign accept    = req_valid && req_ready;
  assign push      = s1_valid_q && !flush;
  assign rsp_valid = (count_q != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_addr  = rsp_valid ? fifo_addr_q[rd_ptr_q] : '0;
  assign rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;

  always_comb begin
    s1_valid_d = accept;
    s1_addr_d  = s1_addr_q;
    s1_data_d  = s1_data_q;
    if (accept) begin
      s1_addr_d = req_addr;
      s1_data_d = mem[req_addr];
    end
  end

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
    end else begin
      if (push) begin
        fifo_addr_d[wr_ptr_q] = s1_addr_q;
        fifo_data_d[wr_ptr_q] = s1_data_q;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop) count_d = count_q + 2'd1;
      if (pop && !push) count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: vector table, hand sequences and an in-order scoreboard.
// Store is preloaded with mem[i] = i ^ 8'h5A.
module tb_imem_fetch;

  logic       clk = 1'b0;
  logic       rst_n, req_valid, rsp_ready, flush;
  logic [7:0] req_addr;
  logic       req_ready, rsp_valid;
  logic [7:0] rsp_addr, rsp_data;
`ifdef IMEM_LOAD_EN
  logic       wr_en;
  logic [7:0] wr_addr, wr_data;
`endif

  always #5 clk = ~clk;

  imem_fetch #(.IW(8), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready),
`ifdef IMEM_LOAD_EN
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`endif
    .flush(flush)
  );

  int errors = 0;
  int checks = 0;
  int max_depth = 0;
  int delivered = 0;
  logic [7:0] model_mem [256];

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic       rst_n;
    logic       req_valid;
    logic [7:0] addr;
    logic       rsp_ready;
    logic       flush;
    logic       e_rr;
    logic       e_rv;
    logic [7:0] e_ra;
  } vec_t;
  vec_t tv [16];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Called at the negedge, once per cycle.
  task automatic sb();
    exp_t e;
    if (rsp_valid && rsp_ready) begin
      delivered++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra got addr=%0h exp none", rsp_addr);
      end else begin
        e = sbq.pop_front();
        check("sb_addr", rsp_addr, e.a);
        check("sb_data", rsp_data, e.d);
      end
    end
    if (!rst_n || flush) sbq.delete();
    else if (req_valid && req_ready)
      sbq.push_back({req_addr, model_mem[req_addr]});
    if (sbq.size() > max_depth) max_depth = sbq.size();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    sb();
    adv();
  endtask

  function automatic vec_t mkv(input logic r, input logic v,
                               input logic [7:0] a, input logic rr_in,
                               input logic f, input logic err,
                               input logic erv, input logic [7:0] era);
    vec_t t;
    t.rst_n = r; t.req_valid = v; t.addr = a; t.rsp_ready = rr_in;
    t.flush = f; t.e_rr = err; t.e_rv = erv; t.e_ra = era;
    return t;
  endfunction

  initial begin
    int n;
    int budget;
    logic [7:0] exp_d;

    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'(i) ^ 8'h5A;
      dut.mem[i]   = model_mem[i];
    end

    rst_n = 0; req_valid = 0; req_addr = 0; rsp_ready = 0; flush = 0;
`ifdef IMEM_LOAD_EN
    wr_en = 0; wr_addr = 0; wr_data = 0;
`endif

    // Reset
    adv();
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_addr", rsp_addr, 0);
    check("rst_rsp_data", rsp_data, 0);
    adv();
    rst_n = 1;

    // Latency/in-order stream, then backpressure at 3
    tv[0]  = mkv(1, 1, 8'h00, 1, 0, 1, 0, 8'h00);
    tv[1]  = mkv(1, 1, 8'h01, 1, 0, 1, 0, 8'h00);
    tv[2]  = mkv(1, 1, 8'h02, 1, 0, 1, 1, 8'h00);
    tv[3]  = mkv(1, 0, 8'h00, 1, 0, 1, 1, 8'h01);
    tv[4]  = mkv(1, 0, 8'h00, 1, 0, 1, 1, 8'h02);
    tv[5]  = mkv(1, 0, 8'h00, 1, 0, 1, 0, 8'h00);
    tv[6]  = mkv(1, 1, 8'h0A, 0, 0, 1, 0, 8'h00);
    tv[7]  = mkv(1, 1, 8'h0B, 0, 0, 1, 0, 8'h00);
    tv[8]  = mkv(1, 1, 8'h0C, 0, 0, 1, 1, 8'h0A);
    tv[9]  = mkv(1, 1, 8'h0D, 0, 0, 0, 1, 8'h0A);
    tv[10] = mkv(1, 1, 8'h0D, 0, 0, 0, 1, 8'h0A);
    tv[11] = mkv(1, 1, 8'h0D, 1, 0, 0, 1, 8'h0A);
    tv[12] = mkv(1, 1, 8'h0D, 1, 0, 1, 1, 8'h0B);
    tv[13] = mkv(1, 0, 8'h00, 1, 0, 1, 1, 8'h0C);
    tv[14] = mkv(1, 0, 8'h00, 1, 0, 1, 1, 8'h0D);
    tv[15] = mkv(1, 0, 8'h00, 1, 0, 1, 0, 8'h00);

    for (int i = 0; i < 16; i++) begin
      rst_n = tv[i].rst_n; req_valid = tv[i].req_valid;
      req_addr = tv[i].addr; rsp_ready = tv[i].rsp_ready;
      flush = tv[i].flush;
      @(negedge clk);
      exp_d = tv[i].e_rv ? model_mem[tv[i].e_ra] : 8'h00;
      check($sformatf("v%0d_req_ready", i), req_ready, tv[i].e_rr);
      check($sformatf("v%0d_rsp_valid", i), rsp_valid, tv[i].e_rv);
      check($sformatf("v%0d_rsp_addr", i), rsp_addr, tv[i].e_ra);
      check($sformatf("v%0d_rsp_data", i), rsp_data, exp_d);
      sb();
      adv();
    end

    // Flush with two fetches in flight
    rsp_ready = 0; req_valid = 1; req_addr = 8'h20;
    cyc();
    req_addr = 8'h21;
    cyc();
    flush = 1; req_addr = 8'h22;
    @(negedge clk);
    check("flush_req_ready", req_ready, 0);
    sb();
    adv();
    flush = 0; req_valid = 0;
    @(negedge clk);
    check("flush_rsp_valid", rsp_valid, 0);
    sb();
    adv();
    req_valid = 1; req_addr = 8'h40; rsp_ready = 1;
    @(negedge clk);
    check("f40_req_ready", req_ready, 1);
    sb();
    adv();
    req_valid = 0;
    cyc();
    @(negedge clk);
    check("f40_rsp_valid", rsp_valid, 1);
    check("f40_rsp_addr", rsp_addr, 8'h40);
    check("f40_rsp_data", rsp_data, 8'h1A);
    sb();
    adv();
    cyc();

    // Reset with a full FIFO
    rsp_ready = 0; req_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      req_addr = 8'(i);
      cyc();
    end
    req_valid = 0;
    cyc();
    @(negedge clk);
    check("full_rsp_valid", rsp_valid, 1);
    check("full_req_ready", req_ready, 0);
    adv();
    rst_n = 0;
    @(negedge clk);
    check("mid_rst_req_ready", req_ready, 0);
    sb();
    adv();
    rst_n = 1;
    @(negedge clk);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_rsp_addr", rsp_addr, 0);
    check("post_rst_rsp_data", rsp_data, 0);
    check("post_rst_req_ready", req_ready, 1);
    sb();
    adv();
    req_valid = 1; req_addr = 8'h03; rsp_ready = 1;
    cyc();
    req_valid = 0;
    cyc();
    @(negedge clk);
    check("refetch3_valid", rsp_valid, 1);
    check("refetch3_data", rsp_data, 8'h59);
    sb();
    adv();
    cyc();

`ifdef IMEM_LOAD_EN
    // Same-cycle write and read: read returns the old word
    wr_en = 1; wr_addr = 8'h07; wr_data = 8'hC3;
    req_valid = 1; req_addr = 8'h07; rsp_ready = 1;
    cyc();
    model_mem[7] = 8'hC3;
    wr_en = 0;
    cyc();
    req_valid = 0;
    cyc();
    @(negedge clk);
    check("load_second_data", rsp_data, 8'hC3);
    sb();
    adv();
    for (int i = 0; i < 3; i++) cyc();
`endif

    // Full-rate wrap-around stream with toggling consumer
    n = 0;
    budget = 0;
    delivered = 0;
    while (n < 257 && budget < 3000) begin
      req_valid = 1;
      req_addr = 8'(n);
      rsp_ready = budget[0];
      @(negedge clk);
      if (req_ready) n++;
      sb();
      adv();
      budget++;
    end
    check("stream_accepted", n, 257);
    req_valid = 0;
    for (int i = 0; i < 20; i++) begin
      rsp_ready = ~rsp_ready;
      cyc();
    end
    check("stream_delivered", delivered, 257);
    check("stream_sb_empty", sbq.size(), 0);
    check("stream_rsp_idle", rsp_valid, 0);
    check("max_in_flight_le3", (max_depth <= 3), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
